// File: rtl/pwm_ramp_if.sv
// pwm_ramp_if: target/step handshake plus compare/status outputs of the duty ramp.
interface pwm_ramp_if #(parameter int W = 8);
   logic [W-1:0] target, step, compare;
   logic         target_valid, target_ready, busy, done;
   modport master (output target, step, target_valid, input target_ready, compare, busy, done);
   modport slave  (input target, step, target_valid, output target_ready, compare, busy, done);
endinterface

// File: rtl/pwm_ramp.sv
// pwm_ramp: steps the pwm compare value toward a requested target, one step per STEP_DIV periods.
module pwm_ramp #(
   parameter int CTR_LEN  = 8,
   parameter int STEP_DIV = 4
) (
   input logic     clk,
   input logic     rst,
   pwm_ramp_if.slave bus
);
   typedef enum logic {IDLE, RAMP} state_t;
   localparam logic [7:0] DL = 8'(STEP_DIV - 1);
   state_t             state, state_n;
   logic [CTR_LEN-1:0] cnt, cmp, cmp_n, tgt, tgt_n, stp, stp_n, nxt;
   logic [CTR_LEN:0]   up, dn;
   logic [7:0]         div, div_n;
   logic               done_q, done_n, boundary;
   assign boundary         = &cnt;
   assign bus.compare      = cmp;
   assign bus.busy         = state == RAMP;
   assign bus.target_ready = state == IDLE;
   assign bus.done         = done_q;
   always_comb begin
      up      = {1'b0, cmp} + {1'b0, stp};
      dn      = {1'b0, cmp} - {1'b0, stp};
      // saturate at the target in both directions; dn[MSB] flags a borrow
      nxt     = (tgt > cmp) ? ((up >= {1'b0, tgt}) ? tgt : up[CTR_LEN-1:0])
                            : ((dn[CTR_LEN] || dn <= {1'b0, tgt}) ? tgt : dn[CTR_LEN-1:0]);
      state_n = state;
      cmp_n   = cmp;
      tgt_n   = tgt;
      stp_n   = stp;
      div_n   = div;
      done_n  = 1'b0;
      if (state == IDLE && bus.target_valid) begin
         tgt_n = bus.target;
         stp_n = (bus.step == '0) ? CTR_LEN'(1) : bus.step;
         div_n = '0;
         if (bus.target == cmp) done_n = 1'b1;
         else state_n = RAMP;
      end else if (state == RAMP && boundary) begin
         if (div == DL) begin
            cmp_n = nxt;
            div_n = '0;
            if (nxt == tgt) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end else div_n = div + 8'd1;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         cmp    <= '0;
         tgt    <= '0;
         stp    <= CTR_LEN'(1);
         div    <= '0;
         done_q <= 1'b0;
      end else begin
         cnt    <= cnt + CTR_LEN'(1);
         cmp    <= cmp_n;
         tgt    <= tgt_n;
         stp    <= stp_n;
         div    <= div_n;
         done_q <= done_n;
      end
   end
endmodule

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 SHALL have parameter CTR_LEN, default 8: width of compare and period counter; matches the downstream pwm counter width.
REQ-002 SHALL have parameter STEP_DIV, default 4: number of PWM periods between ramp steps; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port target  input  CTR_LEN  requested final duty value.
REQ-006 SHALL have port step  input  CTR_LEN  increment/decrement per step; 0 is treated as 1.
REQ-007 SHALL have port target_valid  input  1  target/step offered.
REQ-008 SHALL have port target_ready  output  1  block accepts target/step this cycle.
REQ-009 SHALL have port compare  output  CTR_LEN  duty value driving the downstream pwm compare input; registered.
REQ-010 SHALL have port busy  output  1  ramp in progress.
REQ-011 SHALL have port done  output  1  single-cycle pulse when compare reaches target.

Function
REQ-012 SHALL contain a free-running CTR_LEN-bit period counter, incrementing every clk and wrapping from 2^CTR_LEN-1 to 0.
REQ-013 SHALL define "boundary" as the cycle in which the period counter equals 2^CTR_LEN-1; compare SHALL change only at the clock edge ending a boundary cycle, i.e. coincident with the counter wrapping to 0.
REQ-014 SHALL implement two states: IDLE and RAMP.
REQ-015 IDLE: target_ready=1 and busy=0; RAMP: target_ready=0 and busy=1.
REQ-016 A transfer SHALL occur when target_valid and target_ready are both 1 at a rising clk edge; target and step (0 replaced by 1) are latched on that edge.
REQ-017 On transfer, if the latched target equals compare, state SHALL remain IDLE and done SHALL pulse high for exactly the next cycle.
REQ-018 On transfer, if the latched target differs from compare, state SHALL go to RAMP and the period-divider counter SHALL clear to 0.
REQ-019 In RAMP, each boundary SHALL increment the divider; when the divider equals STEP_DIV-1 at a boundary, a step SHALL be applied and the divider SHALL clear to 0.
REQ-020 A step SHALL move compare toward the latched target by the latched step, saturating at the target: no overshoot and no modular wrap. The arithmetic SHALL be evaluated in CTR_LEN+1 bits.
REQ-021 When a step makes compare equal to the target, the same edge SHALL return the state to IDLE, and done SHALL be high for exactly the following one cycle.
REQ-022 target_valid asserted while in RAMP SHALL be ignored; no latching SHALL occur and there SHALL be no side effects.
REQ-023 If the transfer edge coincides with a boundary edge, compare SHALL NOT change on that edge, and the divider SHALL start from 0.
REQ-024 done and target_ready SHALL never be high in the same cycle as a RAMP-state busy=1.

Reset
REQ-025 While rst=0, outputs SHALL be: compare=0, busy=0, done=0, state=IDLE, period counter=0, divider=0, latched target=0, latched step=1.
REQ-026 target_ready SHALL read 1 during and after reset, because state is IDLE.
REQ-027 Assertion of rst mid-ramp SHALL immediately force compare to 0 and abort the ramp; no done pulse SHALL be produced.
REQ-028 The first post-reset boundary SHALL occur 2^CTR_LEN-1 clk edges after rst deassertion, so the block stays period-aligned with a pwm counter reset on the same cycle.

Verification (CTR_LEN=8)
REQ-029 Reset: hold rst=0 for 3 cycles -> compare=0, busy=0, done=0, target_ready=1; release -> period counter reaches 255 after 255 edges.
REQ-030 Up ramp, STEP_DIV=1: from compare=0, transfer target=128, step=32 -> compare=32,64,96,128 on four successive wraps 256 cycles apart; one done pulse after 128; busy falls on the same edge.
REQ-031 Saturating down ramp, STEP_DIV=1: from compare=128, transfer target=30, step=50 -> compare=78, then 30 (never wraps); single done pulse.
REQ-032 Divider and step=0, STEP_DIV=4: from compare=0, transfer target=3, step=0 -> compare=1,2,3, each change 4 wraps (1024 cycles) apart; all changes occur only at counter wrap.
REQ-033 Null request: transfer target equal to current compare (e.g. 30) -> done high for exactly one cycle next cycle; busy stays 0; compare unchanged.
REQ-034 Interference: target_valid=1 with target=200 during a ramp to 128 -> ignored, ramp ends at 128. Separately, rst=0 mid-ramp -> compare=0 asynchronously, no done, target_ready=1.
